envelope_vca: RTL and testbench

ADSR amplitude envelope and VCA stage placed directly downstream of `integrator` in the voice chain. It consumes the shaped `synthPKG::synth_sig` stream and scales it by a 5-state envelope (IDLE/ATTACK/DECAY/SUSTAIN/RELEASE) driven by a note gate. Envelope rates and sustain level come from register-file values. The envelope advances on a prescaled tick; the multiply is registered.

---
 rtl/envelope_vca_pkg.sv | 12 +
 rtl/envelope_vca_tick.sv | 22 ++
 rtl/envelope_vca.sv | 90 +++++++++
 tb/tb_envelope_vca.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/envelope_vca_pkg.sv
// envelope_vca_pkg: shared widths, sample/register types and envelope FSM states for the voice chain.
package envelope_vca_pkg;
  localparam int SYS_CLK_FREQ = 48_000_000;
  localparam int REG_DATAWIDTH = 16;
  localparam int BITDEPTH = 16;
  localparam int ENV_W = REG_DATAWIDTH;
  typedef logic [REG_DATAWIDTH-1:0] reg_data_t;
  typedef logic signed [BITDEPTH-1:0] synth_sig;
  typedef logic [ENV_W-1:0] env_t;
  localparam env_t ENV_MAX = '1;
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} env_state_t;
endpackage

// File: rtl/envelope_vca_tick.sv
// env_tick_gen: clearable prescaler producing a one-cycle tick every CLK_FREQ/ENV_TICK_HZ clocks.
module env_tick_gen #(
  parameter int CLK_FREQ = 48_000_000,
  parameter int ENV_TICK_HZ = 48000
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);
  localparam int TICK_DIV = CLK_FREQ / ENV_TICK_HZ;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  if (TICK_DIV < 2) begin : g_div_check
    $error("env_tick_gen: TICK_DIV must be at least 2");
  end
  logic [CW-1:0] cnt;
  assign tick = !clear && cnt == LAST;
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/envelope_vca.sv
// envelope_vca: gate-driven ADSR envelope with a registered VCA multiply; bypasses combinationally when disabled.
module envelope_vca
  import envelope_vca_pkg::*;
#(
  parameter int CLK_FREQ = SYS_CLK_FREQ,
  parameter int ENV_TICK_HZ = 48000
) (
  input  logic      clk_in,
  input  logic      reset_n,
  input  logic      enable,
  input  logic      gate,
  input  reg_data_t attack_rate,
  input  reg_data_t decay_rate,
  input  reg_data_t sustain_level,
  input  reg_data_t release_rate,
  input  synth_sig  sig_in,
  output synth_sig  sig_out,
  output env_t      env_out,
  output logic      active
);
  env_state_t state, state_n;
  env_t env, env_n;
  synth_sig vca_reg;
  logic gate_reg, tick, rise, fall, att_done, dec_done, rel_done;
  logic [ENV_W:0] sum, dec, rdec;
  logic signed [BITDEPTH+ENV_W:0] prod;
  logic unused_prod_msb;
  env_tick_gen #(.CLK_FREQ(CLK_FREQ), .ENV_TICK_HZ(ENV_TICK_HZ)) u_tick (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .clear  (!enable),
    .tick   (tick)
  );
  assign rise = gate && !gate_reg;
  assign fall = !gate && gate_reg;
  assign sum = {1'b0, env} + {1'b0, attack_rate};
  assign dec = {1'b0, env} - {1'b0, decay_rate};
  assign rdec = {1'b0, env} - {1'b0, release_rate};
  // A zero rate means "finish this phase on the next tick", so it counts as reaching the target.
  assign att_done = attack_rate == '0 || sum[ENV_W] || &sum[ENV_W-1:0];
  assign dec_done = decay_rate == '0 || dec[ENV_W] || dec[ENV_W-1:0] <= sustain_level;
  assign rel_done = release_rate == '0 || rdec[ENV_W] || rdec[ENV_W-1:0] == '0;
  assign prod = sig_in * $signed({1'b0, env});
  assign unused_prod_msb = prod[BITDEPTH+ENV_W];
  assign sig_out = enable ? vca_reg : sig_in;
  assign env_out = env;
  always_comb begin
    state_n = state;
    env_n = env;
    if (!enable) begin
      state_n = IDLE;
      env_n = '0;
    end else if (rise) begin
      state_n = ATTACK;
    end else if (fall) begin
      state_n = (state == ATTACK || state == DECAY || state == SUSTAIN) ? RELEASE : state;
    end else if (tick) begin
      case (state)
        ATTACK: begin
          env_n = att_done ? ENV_MAX : sum[ENV_W-1:0];
          state_n = att_done ? DECAY : ATTACK;
        end
        DECAY: begin
          env_n = dec_done ? sustain_level : dec[ENV_W-1:0];
          state_n = dec_done ? SUSTAIN : DECAY;
        end
        SUSTAIN: env_n = sustain_level;
        RELEASE: begin
          env_n = rel_done ? '0 : rdec[ENV_W-1:0];
          state_n = rel_done ? IDLE : RELEASE;
        end
        default: env_n = '0;
      endcase
    end
  end
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      env <= '0;
      gate_reg <= 1'b0;
      active <= 1'b0;
      vca_reg <= '0;
    end else begin
      state <= state_n;
      env <= env_n;
      gate_reg <= enable && gate;
      active <= state_n != IDLE;
      vca_reg <= enable ? prod[ENV_W +: BITDEPTH] : '0;
    end
endmodule

// File: tb/tb_envelope_vca.sv
// tb_envelope_vca: scoreboard bench comparing envelope_vca against a cycle model plus directed ADSR checkpoints.
module tb_envelope_vca;
  import envelope_vca_pkg::*;
  localparam int MAXV = 65535;
  localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;
  logic clk_in = 1'b0, reset_n = 1'b0, enable = 1'b0, gate = 1'b0;
  reg_data_t attack_rate = '0, decay_rate = '0, sustain_level = '0, release_rate = '0;
  synth_sig sig_in = '0, sig_out;
  env_t env_out;
  logic active;
  typedef struct {int env; int act; int vca;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int m_st = S_IDLE, m_env = 0, m_cnt = 0;
  bit m_greg = 1'b0;
  int n, held;
  envelope_vca #(.CLK_FREQ(192000), .ENV_TICK_HZ(48000)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .enable(enable), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate), .sustain_level(sustain_level),
    .release_rate(release_rate), .sig_in(sig_in), .sig_out(sig_out), .env_out(env_out),
    .active(active)
  );
  always #5 clk_in = ~clk_in;
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
  task automatic model();
    exp_t e;
    bit tk, up, down;
    int vca, sl;
    sl = int'(sustain_level);
    vca = enable ? (int'(sig_in) * m_env) >>> 16 : 0;
    if (!reset_n) begin
      m_st = S_IDLE; m_env = 0; m_cnt = 0; m_greg = 1'b0; vca = 0;
    end else begin
      tk = enable && m_cnt == 3;
      up = gate && !m_greg;
      down = !gate && m_greg;
      if (!enable) begin
        m_st = S_IDLE; m_env = 0;
      end else if (up) m_st = S_ATT;
      else if (down) begin
        if (m_st inside {S_ATT, S_DEC, S_SUS}) m_st = S_REL;
      end else if (tk) begin
        case (m_st)
          S_ATT: begin
            m_env = attack_rate == 0 ? MAXV : (m_env + int'(attack_rate) > MAXV ? MAXV : m_env + int'(attack_rate));
            if (m_env == MAXV) m_st = S_DEC;
          end
          S_DEC: begin
            m_env = decay_rate == 0 ? sl : imax(m_env - int'(decay_rate), sl);
            if (m_env == sl) m_st = S_SUS;
          end
          S_SUS: m_env = sl;
          S_REL: begin
            m_env = release_rate == 0 ? 0 : imax(m_env - int'(release_rate), 0);
            if (m_env == 0) m_st = S_IDLE;
          end
          default: m_env = 0;
        endcase
      end
      m_cnt = !enable ? 0 : (m_cnt == 3 ? 0 : m_cnt + 1);
      m_greg = enable && gate;
    end
    e.env = m_env;
    e.act = m_st != S_IDLE;
    e.vca = vca;
    q.push_back(e);
  endtask
  task automatic cycle();
    exp_t e;
    model();
    @(posedge clk_in);
    #1;
    e = q.pop_front();
    check("env", env_out, e.env);
    check("active", active, e.act);
    check("sig_out", sig_out, enable ? e.vca : int'(sig_in));
  endtask
  task automatic run_until(input int st, input int limit, input string tag, output int cnt);
    for (cnt = 0; cnt < limit && m_st != st; cnt++) cycle();
    if (m_st != st) check({tag, "_timeout"}, m_st, st);
  endtask
  initial begin
    sig_in = 16'sd1234;
    repeat (3) cycle();
    check("rst_bypass", sig_out, 1234);
    enable = 1'b1;
    cycle();
    check("rst_enabled_sig", sig_out, 0);
    enable = 1'b0;
    reset_n = 1'b1;
    gate = 1'b1;
    repeat (3) cycle();
    gate = 1'b0;
    repeat (3) cycle();
    check("bypass_sig", sig_out, 1234);
    check("bypass_env", env_out, 0);
    check("bypass_active", active, 0);
    attack_rate = 16'h4000; decay_rate = 16'h0100; sustain_level = 16'h7FFF; release_rate = 16'h0200;
    sig_in = -16'sd1000;
    enable = 1'b1;
    gate = 1'b1;
    run_until(S_DEC, 100, "attack", n);
    check("attack_cycles", n, 16);
    check("attack_peak", env_out, MAXV);
    cycle();
    check("vca_full_neg", sig_out, -1000);
    sig_in = 16'sd1000;
    run_until(S_SUS, 2000, "decay", n);
    check("sustain_env", env_out, 16'h7FFF);
    cycle();
    check("vca_half", sig_out, 499);
    gate = 1'b0;
    cycle();
    check("release_active", active, 1);
    run_until(S_IDLE, 2000, "release", n);
    check("idle_active", active, 0);
    check("idle_env", env_out, 0);
    gate = 1'b1;
    run_until(S_SUS, 2000, "retrig_setup", n);
    gate = 1'b0;
    for (int i = 0; i < 2000 && !(m_st == S_REL && m_env <= 16'h3000); i++) cycle();
    held = m_env;
    gate = 1'b1;
    cycle();
    check("retrig_hold", env_out, held);
    check("retrig_active", active, 1);
    for (int i = 0; i < 8 && m_env == held; i++) cycle();
    check("retrig_rise", env_out, held + 16'h4000);
    run_until(S_DEC, 200, "edge_setup", n);
    repeat (6) cycle();
    for (int i = 0; i < 8 && m_cnt != 3; i++) cycle();
    held = m_env;
    gate = 1'b0;
    cycle();
    check("edge_tick_env", env_out, held);
    check("edge_tick_active", active, 1);
    run_until(S_IDLE, 2000, "edge_release", n);
    attack_rate = '0; decay_rate = '0; release_rate = '0; sustain_level = 16'h5000;
    gate = 1'b1;
    run_until(S_DEC, 20, "zero_attack", n);
    check("zero_attack_env", env_out, MAXV);
    run_until(S_SUS, 20, "zero_decay", n);
    check("zero_decay_cycles", n, 4);
    check("zero_sustain_env", env_out, 16'h5000);
    gate = 1'b0;
    cycle();
    run_until(S_IDLE, 20, "zero_release", n);
    check("zero_release_cycles", n <= 4, 1);
    check("zero_release_env", env_out, 0);
    attack_rate = 16'h0100;
    gate = 1'b1;
    run_until(S_ATT, 8, "rst_setup", n);
    repeat (10) cycle();
    reset_n = 1'b0;
    #1;
    check("async_rst_env", env_out, 0);
    check("async_rst_active", active, 0);
    check("async_rst_sig", sig_out, 0);
    repeat (2) cycle();
    reset_n = 1'b1;
    run_until(S_ATT, 8, "post_rst", n);
    for (int i = 0; i < 8 && m_env == 0; i++) cycle();
    check("post_rst_attack", env_out, 16'h0100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
